// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_D  = 1'b1
   } grant_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around the memory port arbiter.
// The slave modport is the arbiter's view; master is the core/memory side.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ready;
   logic [DATA_W-1:0] if_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ready;
   logic [DATA_W-1:0] d_rdata;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_ready, if_rdata, d_ready, d_rdata, mem_addr, mem_we, mem_wdata, busy
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_ready, if_rdata, d_ready, d_rdata, mem_addr, mem_we, mem_wdata, busy
   );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin select: a lone request wins outright, a tie goes to
// the requester that was not granted last.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic   req_if,
   input  logic   req_d,
   input  grant_t last_grant,
   output logic   grant_valid,
   output grant_t grant
);

   // Pick the winner from the current requests and the previous grant
   always_comb begin
      grant_valid = req_if | req_d;
      grant       = GNT_IF;
      if (req_if && req_d) begin
         grant = (last_grant == GNT_IF) ? GNT_D : GNT_IF;
      end else if (req_d) begin
         grant = GNT_D;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one combinational memory between instruction fetch and load/store.
// Each access holds the port for WAIT_CYCLES cycles, then pulses the granted
// requester's ready for one cycle alongside its registered read data.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input logic                clk,
   input logic                rst,
   mem_port_arbiter_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

   state_t            state;
   grant_t            last_grant;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic              if_ready_q;
   logic              d_ready_q;
   logic              grant_valid;
   grant_t            grant;
   logic              done;

   rr_arb2 u_rr_arb2 (
      .req_if      (bus.if_req),
      .req_d       (bus.d_req),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant       (grant)
   );

   // last_grant doubles as the owner of the access in flight
   assign done = (state == ST_ACCESS) && (cnt == '0);

   // Access sequencer: grant and latch in IDLE, count down in ACCESS, one RESP cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         last_grant <= GNT_D;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_valid) begin
                  last_grant <= grant;
                  cnt        <= CNT_LOAD;
                  state      <= ST_ACCESS;
                  if (grant == GNT_IF) begin
                     addr_q  <= bus.if_addr;
                     we_q    <= 1'b0;
                     wdata_q <= '0;
                  end else begin
                     addr_q  <= bus.d_addr;
                     we_q    <= bus.d_we;
                     wdata_q <= bus.d_wdata;
                  end
               end
            end
            ST_ACCESS: begin
               if (cnt == '0) begin
                  state <= ST_RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_RESP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Capture read data for the owner on the final ACCESS cycle and pulse its ready
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_ready_q <= 1'b0;
         d_ready_q  <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         if_ready_q <= 1'b0;
         d_ready_q  <= 1'b0;
         if (done) begin
            if (last_grant == GNT_IF) begin
               if_ready_q <= 1'b1;
               if_rdata_q <= bus.mem_rdata;
            end else begin
               d_ready_q <= 1'b1;
               d_rdata_q <= we_q ? '0 : bus.mem_rdata;
            end
         end
      end
   end

   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_we    = we_q & done;
   assign bus.busy      = (state != ST_IDLE);
   assign bus.if_ready  = if_ready_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_ready   = d_ready_q;
   assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with WAIT_CYCLES=2 and
// one with WAIT_CYCLES=1, each backed by a small word-indexed memory model.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst;
   int   nvec = 0;
   int   nerr = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) u0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) u1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   logic [31:0] mem0 [0:63];
   logic [31:0] mem1 [0:63];

   assign bus0.mem_rdata = mem0[bus0.mem_addr[7:2]];
   assign bus1.mem_rdata = mem1[bus1.mem_addr[7:2]];

   always @(posedge clk) begin
      if (bus0.mem_we) mem0[bus0.mem_addr[7:2]] = bus0.mem_wdata;
      if (bus1.mem_we) mem1[bus1.mem_addr[7:2]] = bus1.mem_wdata;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Runs one fetch on bus0 and reports the cycle of if_ready (-1 if none).
   task automatic f_access(input logic [31:0] addr, output int cyc);
      cyc = -1;
      bus0.if_addr = addr;
      bus0.if_req  = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (bus0.if_ready === 1'b1) begin
            cyc = k;
            break;
         end
      end
      bus0.if_req = 1'b0;
      tick();
   endtask

   // Runs one data access on bus0, reporting ready cycle and write strobes seen.
   task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output int cyc, output int we_cnt,
                           output logic [31:0] we_addr, output logic [31:0] we_data);
      cyc     = -1;
      we_cnt  = 0;
      we_addr = '0;
      we_data = '0;
      bus0.d_we    = we;
      bus0.d_addr  = addr;
      bus0.d_wdata = wdata;
      bus0.d_req   = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (bus0.mem_we === 1'b1) begin
            we_cnt++;
            we_addr = bus0.mem_addr;
            we_data = bus0.mem_wdata;
         end
         if (bus0.d_ready === 1'b1) begin
            cyc = k;
            break;
         end
      end
      bus0.d_req = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      nvec++;
      if ({bus0.if_ready, bus0.if_rdata, bus0.d_ready, bus0.d_rdata, bus0.mem_addr,
           bus0.mem_we, bus0.mem_wdata, bus0.busy} !== '0) begin
         nerr++;
         $display("FAIL reset_outputs_u0: got if_rdy=%b d_rdy=%b mem_addr=%h mem_we=%b busy=%b expected all 0",
                  bus0.if_ready, bus0.d_ready, bus0.mem_addr, bus0.mem_we, bus0.busy);
      end
      nvec++;
      if ({bus1.if_ready, bus1.if_rdata, bus1.d_ready, bus1.d_rdata, bus1.mem_addr,
           bus1.mem_we, bus1.mem_wdata, bus1.busy} !== '0) begin
         nerr++;
         $display("FAIL reset_outputs_u1: got if_rdy=%b d_rdy=%b mem_addr=%h mem_we=%b busy=%b expected all 0",
                  bus1.if_ready, bus1.d_ready, bus1.mem_addr, bus1.mem_we, bus1.busy);
      end
      rst = 1'b0;
      tick();
      nvec++;
      if (bus0.busy !== 1'b0) begin
         nerr++;
         $display("FAIL reset_idle_busy: got %b expected 0", bus0.busy);
      end
   endtask

   task automatic test_single_fetch;
      logic exp_rdy;
      logic we_seen;
      we_seen = 1'b0;
      mem0[2] = 32'hDEADBEEF;
      bus0.if_addr = 32'h8;
      bus0.if_req  = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         if (bus0.mem_we === 1'b1) we_seen = 1'b1;
         exp_rdy = (k == 3);
         nvec++;
         if (bus0.if_ready !== exp_rdy) begin
            nerr++;
            $display("FAIL single_fetch_ready c%0d: got %b expected %b", k, bus0.if_ready, exp_rdy);
         end
         if (k == 3) begin
            bus0.if_req = 1'b0;
            nvec++;
            if (bus0.if_rdata !== 32'hDEADBEEF) begin
               nerr++;
               $display("FAIL single_fetch_rdata: got %h expected deadbeef", bus0.if_rdata);
            end
         end
      end
      nvec++;
      if (we_seen !== 1'b0) begin
         nerr++;
         $display("FAIL single_fetch_no_we: got %b expected 0", we_seen);
      end
      nvec++;
      if (bus0.busy !== 1'b0) begin
         nerr++;
         $display("FAIL single_fetch_idle: got busy=%b expected 0", bus0.busy);
      end
   endtask

   task automatic test_store_load;
      int          cyc;
      int          we_cnt;
      logic [31:0] we_addr;
      logic [31:0] we_data;
      mem0[4] = 32'hAAAA5555;
      d_access(1'b0, 32'h10, 32'h0, cyc, we_cnt, we_addr, we_data);
      nvec++;
      if (cyc !== 3 || bus0.d_rdata !== 32'hAAAA5555 || we_cnt !== 0) begin
         nerr++;
         $display("FAIL load_before_store: got cyc=%0d rdata=%h we_cnt=%0d expected 3 aaaa5555 0",
                  cyc, bus0.d_rdata, we_cnt);
      end
      d_access(1'b1, 32'h10, 32'h12345678, cyc, we_cnt, we_addr, we_data);
      nvec++;
      if (cyc !== 3 || we_cnt !== 1) begin
         nerr++;
         $display("FAIL store_timing: got cyc=%0d we_cnt=%0d expected 3 1", cyc, we_cnt);
      end
      nvec++;
      if (we_addr !== 32'h10 || we_data !== 32'h12345678) begin
         nerr++;
         $display("FAIL store_bus: got addr=%h data=%h expected 00000010 12345678", we_addr, we_data);
      end
      nvec++;
      if (bus0.d_rdata !== 32'h0) begin
         nerr++;
         $display("FAIL store_rdata_zero: got %h expected 0", bus0.d_rdata);
      end
      nvec++;
      if (mem0[4] !== 32'h12345678) begin
         nerr++;
         $display("FAIL store_mem: got %h expected 12345678", mem0[4]);
      end
      d_access(1'b0, 32'h10, 32'h0, cyc, we_cnt, we_addr, we_data);
      nvec++;
      if (cyc !== 3 || bus0.d_rdata !== 32'h12345678) begin
         nerr++;
         $display("FAIL load_after_store: got cyc=%0d rdata=%h expected 3 12345678", cyc, bus0.d_rdata);
      end
      nvec++;
      if (bus0.if_rdata !== 32'hDEADBEEF) begin
         nerr++;
         $display("FAIL if_rdata_untouched: got %h expected deadbeef", bus0.if_rdata);
      end
   endtask

   task automatic test_tie_fairness;
      logic exp_if;
      logic exp_d;
      bus0.if_addr = 32'h8;
      bus0.d_addr  = 32'h10;
      bus0.d_we    = 1'b0;
      bus0.if_req  = 1'b1;
      bus0.d_req   = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         exp_if = (k == 3) || (k == 11);
         exp_d  = (k == 7) || (k == 15);
         nvec++;
         if (bus0.if_ready !== exp_if || bus0.d_ready !== exp_d) begin
            nerr++;
            $display("FAIL tie_order c%0d: got if_rdy=%b d_rdy=%b expected %b %b",
                     k, bus0.if_ready, bus0.d_ready, exp_if, exp_d);
         end
         if (k == 7) begin
            nvec++;
            if (bus0.d_rdata !== 32'h12345678) begin
               nerr++;
               $display("FAIL tie_d_rdata: got %h expected 12345678", bus0.d_rdata);
            end
         end
         if (k == 11) begin
            nvec++;
            if (bus0.if_rdata !== 32'hDEADBEEF) begin
               nerr++;
               $display("FAIL tie_if_rdata: got %h expected deadbeef", bus0.if_rdata);
            end
         end
         if (k == 15) begin
            bus0.if_req = 1'b0;
            bus0.d_req  = 1'b0;
         end
      end
      tick();
      nvec++;
      if (bus0.busy !== 1'b0) begin
         nerr++;
         $display("FAIL tie_idle: got busy=%b expected 0", bus0.busy);
      end
   endtask

   task automatic test_stable_latch;
      mem0[1]  = 32'h11111111;
      mem0[16] = 32'h40404040;
      bus0.if_addr = 32'h4;
      bus0.if_req  = 1'b1;
      tick();
      bus0.if_addr = 32'h40;
      nvec++;
      if (bus0.mem_addr !== 32'h4) begin
         nerr++;
         $display("FAIL latch_addr_c1: got %h expected 00000004", bus0.mem_addr);
      end
      tick();
      nvec++;
      if (bus0.mem_addr !== 32'h4) begin
         nerr++;
         $display("FAIL latch_addr_c2: got %h expected 00000004", bus0.mem_addr);
      end
      tick();
      nvec++;
      if (bus0.if_ready !== 1'b1 || bus0.if_rdata !== 32'h11111111) begin
         nerr++;
         $display("FAIL latch_rdata: got rdy=%b rdata=%h expected 1 11111111", bus0.if_ready, bus0.if_rdata);
      end
      bus0.if_req = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_access;
      int   cyc;
      logic rdy_seen;
      rdy_seen = 1'b0;
      mem0[8] = 32'h5A5A5A5A;
      bus0.d_we    = 1'b1;
      bus0.d_addr  = 32'h20;
      bus0.d_wdata = 32'hFFFFFFFF;
      bus0.d_req   = 1'b1;
      tick();
      tick();
      nvec++;
      if (bus0.mem_we !== 1'b1) begin
         nerr++;
         $display("FAIL abort_we_before: got %b expected 1", bus0.mem_we);
      end
      #2 rst = 1'b1;
      #1;
      nvec++;
      if (bus0.mem_we !== 1'b0 || bus0.busy !== 1'b0 || bus0.d_rdata !== 32'h0) begin
         nerr++;
         $display("FAIL abort_immediate: got we=%b busy=%b d_rdata=%h expected 0 0 0",
                  bus0.mem_we, bus0.busy, bus0.d_rdata);
      end
      bus0.d_req = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (bus0.d_ready === 1'b1) rdy_seen = 1'b1;
      end
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (bus0.d_ready === 1'b1) rdy_seen = 1'b1;
      end
      nvec++;
      if (rdy_seen !== 1'b0) begin
         nerr++;
         $display("FAIL abort_no_ready: got %b expected 0", rdy_seen);
      end
      nvec++;
      if (mem0[8] !== 32'h5A5A5A5A) begin
         nerr++;
         $display("FAIL abort_mem_unchanged: got %h expected 5a5a5a5a", mem0[8]);
      end
      f_access(32'h8, cyc);
      nvec++;
      if (cyc !== 3 || bus0.if_rdata !== 32'hDEADBEEF) begin
         nerr++;
         $display("FAIL abort_recover: got cyc=%0d rdata=%h expected 3 deadbeef", cyc, bus0.if_rdata);
      end
   endtask

   task automatic test_back_to_back;
      logic exp_rdy;
      logic we_seen;
      we_seen = 1'b0;
      mem1[1] = 32'hA1A1A1A1;
      mem1[2] = 32'hA2A2A2A2;
      bus1.if_addr = 32'h4;
      bus1.if_req  = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (bus1.mem_we === 1'b1) we_seen = 1'b1;
         exp_rdy = (k == 2) || (k == 5);
         nvec++;
         if (bus1.if_ready !== exp_rdy) begin
            nerr++;
            $display("FAIL b2b_ready c%0d: got %b expected %b", k, bus1.if_ready, exp_rdy);
         end
         if (k == 2) begin
            nvec++;
            if (bus1.if_rdata !== 32'hA1A1A1A1) begin
               nerr++;
               $display("FAIL b2b_rdata1: got %h expected a1a1a1a1", bus1.if_rdata);
            end
            bus1.if_addr = 32'h8;
         end
         if (k == 4) begin
            nvec++;
            if (bus1.mem_addr !== 32'h8) begin
               nerr++;
               $display("FAIL b2b_addr2: got %h expected 00000008", bus1.mem_addr);
            end
         end
         if (k == 5) begin
            nvec++;
            if (bus1.if_rdata !== 32'hA2A2A2A2) begin
               nerr++;
               $display("FAIL b2b_rdata2: got %h expected a2a2a2a2", bus1.if_rdata);
            end
            bus1.if_req = 1'b0;
         end
      end
      nvec++;
      if (we_seen !== 1'b0) begin
         nerr++;
         $display("FAIL b2b_no_we: got %b expected 0", we_seen);
      end
      bus1.d_we    = 1'b1;
      bus1.d_addr  = 32'hC;
      bus1.d_wdata = 32'hC0FFEE00;
      bus1.d_req   = 1'b1;
      tick();
      nvec++;
      if (bus1.mem_we !== 1'b1 || bus1.mem_addr !== 32'hC || bus1.mem_wdata !== 32'hC0FFEE00) begin
         nerr++;
         $display("FAIL w1_store_strobe: got we=%b addr=%h data=%h expected 1 0000000c c0ffee00",
                  bus1.mem_we, bus1.mem_addr, bus1.mem_wdata);
      end
      tick();
      nvec++;
      if (bus1.d_ready !== 1'b1 || bus1.mem_we !== 1'b0 || mem1[3] !== 32'hC0FFEE00) begin
         nerr++;
         $display("FAIL w1_store_done: got rdy=%b we=%b mem=%h expected 1 0 c0ffee00",
                  bus1.d_ready, bus1.mem_we, mem1[3]);
      end
      bus1.d_req = 1'b0;
      tick();
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem0[i] = '0;
         mem1[i] = '0;
      end
      bus0.if_req = 1'b0; bus0.if_addr = '0;
      bus0.d_req  = 1'b0; bus0.d_we = 1'b0; bus0.d_addr = '0; bus0.d_wdata = '0;
      bus1.if_req = 1'b0; bus1.if_addr = '0;
      bus1.d_req  = 1'b0; bus1.d_we = 1'b0; bus1.d_addr = '0; bus1.d_wdata = '0;
      rst = 1'b1;

      test_reset();
      test_single_fetch();
      test_store_load();
      test_tie_fairness();
      test_stable_latch();
      test_reset_mid_access();
      test_back_to_back();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
